// File: rtl/store_drain_buffer.sv
// Store drain buffer: queues committed stores and drains them onto the dcache write ports.
// Optional store-to-load forwarding is enabled by defining STORE_FWD_EN.
`timescale 1ns/1ps
module store_drain_buffer #(
  parameter int          DEPTH     = 8,
  parameter int          IDX_W     = 11,
  parameter logic [63:0] PARK_ADDR = 64'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st0_valid,
  input  logic [63:0] st0_addr,
  input  logic [63:0] st0_data,
  input  logic        st1_valid,
  input  logic [63:0] st1_addr,
  input  logic [63:0] st1_data,
  output logic        st_ready,
  input  logic        drain_hold,
  output logic [63:0] wr_addr_high,
  output logic [63:0] wr_data_high,
  output logic [63:0] wr_addr_low,
  output logic [63:0] wr_data_low,
  output logic [63:0] rb_addr,
  input  logic [63:0] rb_data,
  input  logic [63:0] ld_addr,
  output logic        ld_hit,
  output logic [63:0] ld_data,
  output logic        ld_stall,
  output logic        empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [63:0]   ent_addr [DEPTH];
  logic [63:0]   ent_data [DEPTH];

  logic [1:0]    n_drain;
  logic [1:0]    n_push;
  logic [PW-1:0] head1;
  logic [PW-1:0] tail1;
  logic [PW-1:0] lane1_pos;
  logic          lk_hit;
  logic [63:0]   lk_data;
  logic [PW-1:0] lk_idx;

  assign st_ready  = count <= CW'(DEPTH - 2);
  assign empty     = count == '0;
  assign head1     = head + PW'(1);
  assign tail1     = tail + PW'(1);
  assign lane1_pos = st0_valid ? tail1 : tail;
  assign rb_addr   = PARK_ADDR;

  // Drain width and accepted push count for this cycle.
  always_comb begin
    n_drain = 2'd0;
    n_push  = 2'd0;
    if (!drain_hold && count != '0)
      n_drain = (count == CW'(1)) ? 2'd1 : 2'd2;
    if (st_ready)
      n_push = {1'b0, st0_valid} + {1'b0, st1_valid};
  end

  // Write-port steering: two oldest, oldest twice, or park rewrite.
  always_comb begin
    wr_addr_high = PARK_ADDR;
    wr_data_high = rb_data;
    wr_addr_low  = PARK_ADDR;
    wr_data_low  = rb_data;
    unique case (1'b1)
      n_drain == 2'd2: begin
        wr_addr_high = ent_addr[head];
        wr_data_high = ent_data[head];
        wr_addr_low  = ent_addr[head1];
        wr_data_low  = ent_data[head1];
      end
      n_drain == 2'd1: begin
        wr_addr_high = ent_addr[head];
        wr_data_high = ent_data[head];
        wr_addr_low  = ent_addr[head];
        wr_data_low  = ent_data[head];
      end
      default: ;
    endcase
  end

  // Scan oldest to youngest so the last match is the youngest.
  always_comb begin
    lk_hit  = 1'b0;
    lk_data = '0;
    lk_idx  = head;
    for (int k = 0; k < DEPTH; k++) begin
      lk_idx = head + PW'(k);
      if (CW'(k) < count &&
          ent_addr[lk_idx][IDX_W-1:0] == ld_addr[IDX_W-1:0]) begin
        lk_hit  = 1'b1;
        lk_data = ent_data[lk_idx];
      end
    end
  end

  assign ld_hit = lk_hit;

`ifdef STORE_FWD_EN
  assign ld_data  = lk_data;
  assign ld_stall = 1'b0;
`else
  assign ld_data  = '0;
  assign ld_stall = lk_hit;
  logic unused_fwd;
  assign unused_fwd = ^lk_data;
`endif

  logic unused_ld;
  assign unused_ld = ^ld_addr[63:IDX_W];

  // Pointer and occupancy update; reset discards all buffered stores.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(n_drain);
      tail  <= tail + PW'(n_push);
      count <= count + CW'(n_push) - CW'(n_drain);
    end
  end

  // Entry storage; contents beyond count are don't-care.
  always_ff @(posedge clk) begin
    if (st_ready && st0_valid) begin
      ent_addr[tail] <= st0_addr;
      ent_data[tail] <= st0_data;
    end
    if (st_ready && st1_valid) begin
      ent_addr[lane1_pos] <= st1_addr;
      ent_data[lane1_pos] <= st1_data;
    end
  end

endmodule

// File: tb/tb_store_drain_buffer.sv
// Bench for store_drain_buffer: directed scenarios then random traffic,
// checked against a queue-based model and a model of the dcache array.
`timescale 1ns/1ps
module tb_store_drain_buffer;

  localparam int          DEPTH = 8;
  localparam int          IDX_W = 11;
  localparam logic [63:0] PARK  = 64'h0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st0_valid, st1_valid;
  logic [63:0] st0_addr, st0_data, st1_addr, st1_data;
  logic        st_ready;
  logic        drain_hold;
  logic [63:0] wr_addr_high, wr_data_high;
  logic [63:0] wr_addr_low, wr_data_low;
  logic [63:0] rb_addr, rb_data;
  logic [63:0] ld_addr;
  logic        ld_hit, ld_stall, empty;
  logic [63:0] ld_data;

  store_drain_buffer #(
    .DEPTH(DEPTH), .IDX_W(IDX_W), .PARK_ADDR(PARK)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .st0_valid(st0_valid), .st0_addr(st0_addr), .st0_data(st0_data),
    .st1_valid(st1_valid), .st1_addr(st1_addr), .st1_data(st1_data),
    .st_ready(st_ready), .drain_hold(drain_hold),
    .wr_addr_high(wr_addr_high), .wr_data_high(wr_data_high),
    .wr_addr_low(wr_addr_low), .wr_data_low(wr_data_low),
    .rb_addr(rb_addr), .rb_data(rb_data),
    .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
    .ld_stall(ld_stall), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a;
    logic [63:0] d;
  } ent_t;

  ent_t        q[$];
  logic [63:0] arr_dut [2048];
  logic [63:0] arr_ref [2048];
  int          vecs = 0;
  int          errs = 0;
  int          e_n;
  logic        e_ready;
  logic [63:0] e_ha, e_hd, e_la, e_ld;

  assign rb_data = arr_dut[rb_addr[IDX_W-1:0]];

  // Array as seen by the DUT: high then low, so low wins on collision.
  always @(posedge clk) begin
    arr_dut[wr_addr_high[IDX_W-1:0]] = wr_data_high;
    arr_dut[wr_addr_low[IDX_W-1:0]]  = wr_data_low;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int          sz;
    logic        hit;
    logic [63:0] hd;
    logic [63:0] pa;
    pa  = PARK;
    sz  = q.size();
    e_n = (drain_hold || sz == 0) ? 0 : (sz >= 2 ? 2 : 1);
    e_ready = (DEPTH - sz) >= 2;
    if (e_n == 2) begin
      e_ha = q[0].a; e_hd = q[0].d; e_la = q[1].a; e_ld = q[1].d;
    end else if (e_n == 1) begin
      e_ha = q[0].a; e_hd = q[0].d; e_la = q[0].a; e_ld = q[0].d;
    end else begin
      e_ha = pa; e_hd = arr_ref[pa[IDX_W-1:0]];
      e_la = pa; e_ld = arr_ref[pa[IDX_W-1:0]];
    end
    hit = 1'b0;
    hd  = '0;
    foreach (q[i])
      if (q[i].a[IDX_W-1:0] == ld_addr[IDX_W-1:0]) begin
        hit = 1'b1;
        hd  = q[i].d;
      end
    chk("st_ready", 64'(st_ready), 64'(e_ready));
    chk("empty", 64'(empty), 64'(sz == 0));
    chk("wr_addr_high", wr_addr_high, e_ha);
    chk("wr_data_high", wr_data_high, e_hd);
    chk("wr_addr_low", wr_addr_low, e_la);
    chk("wr_data_low", wr_data_low, e_ld);
    chk("rb_addr", rb_addr, pa);
    chk("ld_hit", 64'(ld_hit), 64'(hit));
`ifdef STORE_FWD_EN
    chk("ld_data", ld_data, hd);
    chk("ld_stall", 64'(ld_stall), 64'(0));
`else
    chk("ld_data", ld_data, 64'(0));
    chk("ld_stall", 64'(ld_stall), 64'(hit));
`endif
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    arr_ref[e_ha[IDX_W-1:0]] = e_hd;
    arr_ref[e_la[IDX_W-1:0]] = e_ld;
    for (int i = 0; i < e_n; i++) void'(q.pop_front());
    if (e_ready && rst_n) begin
      if (st0_valid) q.push_back('{st0_addr, st0_data});
      if (st1_valid) q.push_back('{st1_addr, st1_data});
    end
    #1;
  endtask

  task automatic drive(input logic v0, input logic [63:0] a0,
                       input logic [63:0] d0, input logic v1,
                       input logic [63:0] a1, input logic [63:0] d1);
    st0_valid = v0; st0_addr = a0; st0_data = d0;
    st1_valid = v1; st1_addr = a1; st1_data = d1;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic drain_all();
    drain_hold = 1'b0;
    idle();
    for (int i = 0; i < 12 && q.size() != 0; i++) step();
    step();
    chk("drained", 64'(empty), 64'(1));
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) begin
      arr_dut[i] = '0;
      arr_ref[i] = '0;
    end
    arr_dut[0] = 64'h55;
    arr_ref[0] = 64'h55;
    rst_n = 1'b0;
    drain_hold = 1'b0;
    ld_addr = 64'h7ff;
    idle();
    #2;
    check_outputs();
    #20;
    rst_n = 1'b1;
    #3;

    // idle: park rewrites only
    for (int i = 0; i < 3; i++) step();
    chk("park_arr0", arr_dut[0], 64'h55);

    // hold, push three, release
    drain_hold = 1'b1;
    drive(1'b1, 64'h10, 64'hA, 1'b1, 64'h11, 64'hB);
    step();
    drive(1'b1, 64'h12, 64'hC, 1'b0, '0, '0);
    step();
    idle();
    step();
    drain_hold = 1'b0;
    step();
    step();
    step();
    chk("arr_10", arr_dut[11'h10], 64'hA);
    chk("arr_11", arr_dut[11'h11], 64'hB);
    chk("arr_12", arr_dut[11'h12], 64'hC);
    chk("empty_after_3", 64'(empty), 64'(1));

    // fill to 8, drop while not ready, drain with wrap
    drain_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 64'(16'h100 + 2 * i), 64'(32'hF000 + 2 * i),
            1'b1, 64'(16'h101 + 2 * i), 64'(32'hF001 + 2 * i));
      step();
    end
    drive(1'b1, 64'h1F0, 64'hDEAD, 1'b1, 64'h1F1, 64'hBEEF);
    step();
    chk("full_ready", 64'(st_ready), 64'(0));
    chk("full_qsize", 64'(q.size()), 64'(8));
    drain_all();
    chk("dropped", arr_dut[11'h1F0], 64'h0);
    chk("arr_107", arr_dut[11'h107], 64'hF007);

    // same-index pair: low wins
    drain_hold = 1'b1;
    drive(1'b1, 64'h20, 64'h1111, 1'b1, 64'h820, 64'h2222);
    step();
    drain_all();
    chk("same_idx", arr_dut[11'h20], 64'h2222);

    // forwarding / stall on duplicate address
    drain_hold = 1'b1;
    drive(1'b1, 64'h30, 64'hD1, 1'b1, 64'h30, 64'hD2);
    ld_addr = 64'h30;
    step();
    idle();
    step();
    chk("ld_hit_30", 64'(ld_hit), 64'(1));
`ifdef STORE_FWD_EN
    chk("ld_data_30", ld_data, 64'hD2);
`else
    chk("ld_stall_30", 64'(ld_stall), 64'(1));
`endif
    drain_all();
    chk("ld_hit_gone", 64'(ld_hit), 64'(0));

    // reset with five entries buffered
    drain_hold = 1'b1;
    drive(1'b1, 64'h40, 64'h40, 1'b1, 64'h41, 64'h41);
    step();
    step();
    drive(1'b1, 64'h44, 64'h44, 1'b0, '0, '0);
    step();
    idle();
    chk("pre_rst_q", 64'(q.size()), 64'(5));
    rst_n = 1'b0;
    q.delete();
    #1;
    check_outputs();
    step();
    step();
    rst_n = 1'b1;
    drain_hold = 1'b0;
    step();
    chk("rst_arr40", arr_dut[11'h40], 64'h0);

    // random traffic
    for (int c = 0; c < 600; c++) begin
      logic [63:0] a0, a1;
      a0 = {$urandom(), $urandom()};
      a1 = {$urandom(), $urandom()};
      a0[IDX_W-1:0] = 11'(32'h50 + $urandom_range(0, 7));
      a1[IDX_W-1:0] = 11'(32'h50 + $urandom_range(0, 7));
      drain_hold = ($urandom_range(0, 3) == 0);
      drive(1'($urandom()), a0, {$urandom(), $urandom()},
            1'($urandom()), a1, {$urandom(), $urandom()});
      ld_addr = 64'(32'h50 + $urandom_range(0, 9));
      step();
    end
    drain_all();
    for (int i = 0; i < 2048; i++)
      chk("array", arr_dut[i], arr_ref[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
